// File: rtl/issue_hazard_ctrl.sv
// rtl/issue_hazard_ctrl.sv - issue-stage scoreboard, in-flight limiter and flush sequencer
module issue_hazard_ctrl #(
  parameter int pRegNum      = 32,
  parameter int pMaxInFlight = 4,
  parameter int pFlushCycles = 2,
  localparam int cRegSelBitW = $clog2(pRegNum)
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iDecDv,
  input  logic [cRegSelBitW-1:0] iRs1Addr,
  input  logic [cRegSelBitW-1:0] iRs2Addr,
  input  logic [cRegSelBitW-1:0] iRdAddr,
  input  logic                   iUseRs1,
  input  logic                   iUseRs2,
  input  logic                   iWriteRd,
  input  logic                   iFlushReq,
  input  logic                   iWbDv,
  input  logic [cRegSelBitW-1:0] iWbAddr,
  output logic                   oStall,
  output logic                   oIssueDv,
  output logic                   oFlush,
  output logic [pRegNum-1:0]     oBusyMask,
  output logic [3:0]             oInFlight
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] cMaxCnt   = 4'(pMaxInFlight);
  localparam logic [2:0] cFlushLd  = 3'(pFlushCycles - 1);

  state_t           state, stateNext;
  logic [2:0]       flushCnt, flushCntNext;
  logic [pRegNum-1:0] effBusy, busyNext;
  logic             haz, full, issue, setEn, clrEn;
  logic [3:0]       inFlightNext;

  // Same-cycle writeback makes the released register visible as free already
  always_comb begin
    effBusy = oBusyMask;
    if (iWbDv) effBusy[iWbAddr] = 1'b0;
  end

  assign haz   = (iUseRs1 & effBusy[iRs1Addr]) | (iUseRs2 & effBusy[iRs2Addr]) |
                 (iWriteRd & effBusy[iRdAddr]);
  assign full  = iWriteRd & (iRdAddr != '0) & (oInFlight == cMaxCnt) & ~iWbDv;
  assign oStall = (state == RUN) & iDecDv & (haz | full);
  assign issue = (state == RUN) & iDecDv & ~oStall & ~iFlushReq;
  assign setEn = issue & iWriteRd & (iRdAddr != '0);
  assign clrEn = iWbDv & (iWbAddr != '0) & oBusyMask[iWbAddr];

  always_comb begin
    stateNext    = state;
    flushCntNext = flushCnt;
    if (iFlushReq) begin
      stateNext    = FLUSH;
      flushCntNext = cFlushLd;
    end else if (state == FLUSH) begin
      if (flushCnt == 3'd0) stateNext = RUN;
      else flushCntNext = flushCnt - 3'd1;
    end
  end

  // Clear before set so a same-register set/clear leaves the bit busy
  always_comb begin
    busyNext     = oBusyMask;
    inFlightNext = oInFlight;
    if (clrEn) busyNext[iWbAddr] = 1'b0;
    if (setEn) busyNext[iRdAddr] = 1'b1;
    busyNext[0] = 1'b0;
    if (setEn && !clrEn && oInFlight != cMaxCnt) inFlightNext = oInFlight + 4'd1;
    else if (clrEn && !setEn && oInFlight != 4'd0) inFlightNext = oInFlight - 4'd1;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= RUN;
      flushCnt  <= 3'd0;
      oBusyMask <= '0;
      oInFlight <= 4'd0;
      oIssueDv  <= 1'b0;
      oFlush    <= 1'b0;
    end else begin
      state     <= stateNext;
      flushCnt  <= flushCntNext;
      oBusyMask <= busyNext;
      oInFlight <= inFlightNext;
      oIssueDv  <= issue;
      oFlush    <= iFlushReq;
    end
  end

endmodule

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
Issue-stage controller between instruction fetch/decode and execute. It keeps a register scoreboard of in-flight destination registers and holds back decoded instructions until their operands are safe. It limits the number of outstanding writes and sequences the pipeline flush/bubble window after a taken branch or jump. It drives the stall back to fetch and to the decoder, and the issue-valid toward execute.

Parameters:
pRegNum, 32, number of architectural registers; register index width is cRegSelBitW, and x0 is index 0.
pMaxInFlight, 4, maximum number of outstanding register-writing instructions (1..15).
pFlushCycles, 2, number of bubble cycles after a flush request; must equal the decoder pipeline depth (1..7).

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  synchronous reset, active-high
iDecDv  in  1  decoded instruction valid
iRs1Addr  in  cRegSelBitW  source 1 index
iRs2Addr  in  cRegSelBitW  source 2 index
iRdAddr  in  cRegSelBitW  destination index
iUseRs1  in  1  instruction reads rs1
iUseRs2  in  1  instruction reads rs2
iWriteRd  in  1  instruction writes rd
iFlushReq  in  1  one-cycle pulse from execute: branch taken or jump
iWbDv  in  1  retire-or-kill of one in-flight write (squashed instructions also report here)
iWbAddr  in  cRegSelBitW  register being released
oStall  out  1  combinational; hold fetch and decoder registers this cycle
oIssueDv  out  1  registered; instruction accepted into execute
oFlush  out  1  registered; kill decoder contents
oBusyMask  out  pRegNum  registered scoreboard, for debug and verification
oInFlight  out  4  registered count of outstanding writes

Behaviour:
- Reset (synchronous, iRst=1 at a clock edge):
  - oBusyMask=0, oInFlight=0, oIssueDv=0, oFlush=0, flush counter=0, FSM=RUN.
  - Reset has priority over every other input, including mid-flush.
- FSM has two states, RUN and FLUSH.
  - RUN to FLUSH: iFlushReq=1. The counter loads pFlushCycles-1 and oFlush=1 on the next cycle only.
  - FLUSH: the counter decrements each cycle; the FSM returns to RUN when the counter is 0 at a clock edge.
  - An iFlushReq seen while in FLUSH reloads the counter and pulses oFlush again.
- Hazard term, evaluated combinationally in RUN:
  - eff = oBusyMask with bit iWbAddr cleared when iWbDv=1 (same-cycle writeback bypass).
  - haz = (iUseRs1 & eff[iRs1Addr]) | (iUseRs2 & eff[iRs2Addr]) | (iWriteRd & eff[iRdAddr]).
  - The rd term is the WAW check.
  - Reads or writes of x0 never hazard, since bit 0 of the mask is always 0.
- Full term: full = iWriteRd & iRdAddr!=0 & (oInFlight == pMaxInFlight) & ~iWbDv.
- oStall = iDecDv & (haz | full) in RUN. In FLUSH, oStall=0 and iDecDv is ignored (instruction discarded).
- Issue: in RUN with iDecDv=1, oStall=0 and iFlushReq=0, oIssueDv=1 on the next cycle; otherwise oIssueDv=0. iFlushReq in the same cycle as iDecDv suppresses the issue. Latency from accept to oIssueDv is 1 cycle.
- Scoreboard update at each edge:
  - On issue with iWriteRd=1 and iRdAddr!=0: set busy[iRdAddr] and increment the count.
  - On iWbDv: clear busy[iWbAddr] and decrement the count.
  - Both in the same cycle to the same register: set wins, and the count is unchanged.
  - Both to different registers: both updates apply, and the count is unchanged.
  - iWbAddr=0 is ignored.
- Protocol errors:
  - iWbDv on a register that is not busy is ignored; the count does not change.
  - The count saturates at 0 and at pMaxInFlight.
- The scoreboard persists across a flush. Execute releases squashed entries through the iWb port.

Test Plan:
1. RAW stall: issue ADD x5 (rd=5). The next instruction reads rs1=5 -> oStall=1 until iWbDv with iWbAddr=5. In that cycle oStall=0 (bypass) and oIssueDv=1 one cycle later. oBusyMask[5] goes 1 then 0.
2. x0 handling: issue writes to rd=0 ten times -> oBusyMask stays 0, oInFlight stays 0, no stall.
3. Capacity: issue writes to x1..x4 with pMaxInFlight=4 -> oInFlight=4. A fifth write to x6 stalls; a wb of x2 in the same cycle releases it, and oInFlight stays 4.
4. Flush: pulse iFlushReq with iDecDv=1 -> no issue, oFlush=1 for exactly 1 cycle. oIssueDv=0 for 2 cycles (pFlushCycles=2) while iDecDv is held 1, then issue resumes.
5. Simultaneous set/clear: busy[7]=1; wb x7 and issue of a new rd=7 in the same cycle -> busy[7]=1 and oInFlight unchanged.
6. Reset mid-FLUSH with busy[3]=1 and oInFlight=1 -> next cycle all outputs 0, FSM=RUN, and an instruction reading x3 issues without stall.
